// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer: FSM state encoding and
// the prescaler width calculation used by both the top level and the prescaler.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // Prescaler counter width for a given PRESCALE, i.e. $clog2(PRESCALE+1).
    function automatic int prescale_width(input int prescale);
        return $clog2(prescale + 1);
    endfunction

endpackage

// File: rtl/countdown_timer8_if.sv
// Control/status bundle of the countdown timer; the timer takes the slave side,
// whoever loads and starts it takes the master side.
interface countdown_timer8_if #(
    parameter int WIDTH = 8
);

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output load, load_val, start, pause,
        input  cnt, busy, done, zero
    );

    modport slave (
        input  load, load_val, start, pause,
        output cnt, busy, done, zero
    );

endinterface

// File: rtl/countdown_timer8_tick_prescaler.sv
// Clock prescaler for the countdown timer: counts 0..PRESCALE-1 while enabled
// and flags the terminal count as a tick in the same cycle.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    assign tick = en && (pcnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer8.sv
// Loadable, pausable down-counter with prescaler and one-cycle done pulse.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN for periodic auto-reload.
module countdown_timer8
    import timer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input logic               clk,
    input logic               rst,
    countdown_timer8_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_nx;
    logic             busy_q;
    logic             done_q;
    logic             presc_clr;
    logic             presc_en;
    logic             tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    // HOLD with pause released behaves like RUN so each paused cycle costs exactly one cycle.
    assign presc_en  = !bus.load && !bus.pause && (state == RUN || state == HOLD);
    assign presc_clr = bus.load || (state == IDLE && bus.start) || (state == DONE);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_q;
        if (bus.load) begin
            cnt_nx   = bus.load_val;
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nx = (cnt_q != '0) ? RUN : DONE;
                    end
                end
                RUN, HOLD: begin
                    if (bus.pause) begin
                        state_nx = HOLD;
                    end else begin
                        state_nx = RUN;
                        if (tick && cnt_q != '0) begin
                            cnt_nx = cnt_q - WIDTH'(1);
                            if (cnt_q == WIDTH'(1)) begin
                                state_nx = DONE;
                            end
                        end
                    end
                end
                DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (reload_q != '0) begin
                        cnt_nx   = reload_q;
                        state_nx = RUN;
                    end else begin
                        state_nx = IDLE;
                    end
`else
                    cnt_nx   = '0;
                    state_nx = IDLE;
`endif
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state  <= state_nx;
            cnt_q  <= cnt_nx;
            busy_q <= (state_nx == RUN) || (state_nx == HOLD);
            done_q <= (state_nx == DONE);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (bus.load) begin
                reload_q <= bus.load_val;
            end
`endif
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.zero = (cnt_q == '0);

endmodule

// File: tb/tb_countdown_timer8.sv
// Self-checking bench: a PRESCALE=1 and a PRESCALE=3 timer driven in lockstep and
// compared against a count-of-active-cycles reference model (honours COUNTDOWN_AUTO_RELOAD_EN).
module tb_countdown_timer8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer8_if #(.WIDTH(8)) bus1 ();
    countdown_timer8_if #(.WIDTH(8)) bus3 ();

    countdown_timer8 #(.WIDTH(8), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    countdown_timer8 #(.WIDTH(8), .PRESCALE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    always #5 clk = ~clk;

    // Reference: while running, cnt = n0 - floor(active/P), done when active == n0*P.
    typedef struct {
        int cnt;
        int reload;
        bit running;
        bit done;
        int n0;
        int active;
    } mdl_t;

    mdl_t m1 = '{0, 0, 1'b0, 1'b0, 0, 0};
    mdl_t m3 = '{0, 0, 1'b0, 1'b0, 0, 0};

    function automatic mdl_t step(mdl_t m, bit r, bit l, int v, bit s, bit p, int ps);
        mdl_t n = m;
        n.done = 1'b0;
        if (r) begin
            n = '{0, 0, 1'b0, 1'b0, 0, 0};
            return n;
        end
        if (l) begin
            n.cnt = v;
            n.reload = v;
            n.running = 1'b0;
            return n;
        end
        if (m.done) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (m.reload != 0) begin
                n.cnt = m.reload;
                n.n0 = m.reload;
                n.active = 0;
                n.running = 1'b1;
            end
`endif
            return n;
        end
        if (m.running) begin
            if (p) return n;
            n.active = m.active + 1;
            n.cnt = m.n0 - n.active / ps;
            if (n.active == m.n0 * ps) begin
                n.running = 1'b0;
                n.done = 1'b1;
            end
            return n;
        end
        if (s) begin
            if (m.cnt != 0) begin
                n.running = 1'b1;
                n.n0 = m.cnt;
                n.active = 0;
            end else begin
                n.done = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        chk("p1_cnt",  int'(bus1.cnt),  m1.cnt);
        chk("p1_busy", int'(bus1.busy), int'(m1.running));
        chk("p1_done", int'(bus1.done), int'(m1.done));
        chk("p1_zero", int'(bus1.zero), int'(m1.cnt == 0));
        chk("p3_cnt",  int'(bus3.cnt),  m3.cnt);
        chk("p3_busy", int'(bus3.busy), int'(m3.running));
        chk("p3_done", int'(bus3.done), int'(m3.done));
        chk("p3_zero", int'(bus3.zero), int'(m3.cnt == 0));
    endtask

    // Drive both timers identically for one edge, advance the models, then check.
    task automatic applyStimulus(input bit r, input bit l, input logic [7:0] v, input bit s, input bit p);
        rst = r;
        bus1.load = l;  bus1.load_val = v;  bus1.start = s;  bus1.pause = p;
        bus3.load = l;  bus3.load_val = v;  bus3.start = s;  bus3.pause = p;
        @(posedge clk);
        m1 = step(m1, r, l, int'(v), s, p, 1);
        m3 = step(m3, r, l, int'(v), s, p, 3);
        #1;
        checkOutput();
    endtask

    typedef struct {
        bit         rst;
        bit         load;
        logic [7:0] lv;
        bit         start;
        bit         pause;
        int         cnt;
        bit         busy;
        bit         done;
        bit         zero;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int t1, t3, got, prev1, prev3, nd1, nd3;
        bit found;

        // Expected values are for the PRESCALE=1 instance.
        tbl[0]  = '{1'b1, 1'b1, 8'd99,  1'b1, 1'b0,   0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 8'd5,   1'b0, 1'b0,   5, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0,   5, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0,   4, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0,   3, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0,   2, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0,   1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0,   0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 8'd0,   1'b0, 1'b0,   0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0,   0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0,   0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 8'd3,   1'b0, 1'b0,   3, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0,   3, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1,   3, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1,   3, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0,   2, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0,   1, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 8'd200, 1'b0, 1'b1, 200, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 200, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0,   0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 20; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].load, tbl[i].lv, tbl[i].start, tbl[i].pause);
            chk($sformatf("tbl%0d_cnt", i),  int'(bus1.cnt),  tbl[i].cnt);
            chk($sformatf("tbl%0d_busy", i), int'(bus1.busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), int'(bus1.done), int'(tbl[i].done));
            chk($sformatf("tbl%0d_zero", i), int'(bus1.zero), int'(tbl[i].zero));
        end

        // PRESCALE=3, load 2, pause for 4 edges starting mid-prescale.
        applyStimulus(0, 1, 8'd2, 0, 0);
        applyStimulus(0, 0, 8'd0, 1, 0);
        got = -1;
        for (int c = 1; c <= 40; c++) begin
            applyStimulus(0, 0, 8'd0, 0, (c >= 2 && c <= 5));
            if (c <= 5) chk("p3_pause_cnt_stable", int'(bus3.cnt), 2);
            if (bus3.done) begin
                got = c;
                break;
            end
        end
        chk("p3_pause_done_edge", got, 10);
        applyStimulus(0, 0, 8'd0, 0, 0);
        applyStimulus(0, 0, 8'd0, 0, 0);

        // Abort a long count with a reload, then restart it.
        applyStimulus(0, 1, 8'd200, 0, 0);
        applyStimulus(0, 0, 8'd0, 1, 0);
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            applyStimulus(0, 0, 8'd0, 0, 0);
            if (bus1.cnt == 8'd120) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reached_120", int'(found), 1);
        applyStimulus(0, 1, 8'd7, 0, 0);
        chk("abort_p1_cnt", int'(bus1.cnt), 7);
        chk("abort_p1_busy", int'(bus1.busy), 0);
        chk("abort_p1_done", int'(bus1.done), 0);
        chk("abort_p3_cnt", int'(bus3.cnt), 7);
        applyStimulus(0, 0, 8'd0, 1, 0);
        t1 = -1;
        t3 = -1;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(0, 0, 8'd0, 0, 0);
            if (bus1.done && t1 < 0) t1 = k;
            if (bus3.done && t3 < 0) t3 = k;
            if (t3 >= 0) break;
        end
        chk("restart_p1_done_edge", t1, 7);
        chk("restart_p3_done_edge", t3, 21);
        applyStimulus(0, 1, 8'd0, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Periodic done: period N*P+1.
        applyStimulus(0, 1, 8'd3, 0, 0);
        applyStimulus(0, 0, 8'd0, 1, 0);
        prev1 = -1;
        prev3 = -1;
        nd1 = 0;
        nd3 = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(0, 0, 8'd0, 0, 0);
            if (bus1.done) begin
                if (prev1 < 0) chk("auto_p1_first", k, 3);
                else chk("auto_p1_period", k - prev1, 4);
                prev1 = k;
                nd1++;
            end
            if (bus3.done) begin
                if (prev3 < 0) chk("auto_p3_first", k, 9);
                else chk("auto_p3_period", k - prev3, 10);
                prev3 = k;
                nd3++;
            end
        end
        chk("auto_p1_pulses", nd1, 10);
        chk("auto_p3_pulses", nd3, 4);
        applyStimulus(0, 1, 8'd0, 0, 0);
`else
        prev1 = 0;
        prev3 = 0;
        nd1 = 0;
        nd3 = 0;
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            bit         r, l, s, p;
            logic [7:0] v;
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 6);
            s = ($urandom_range(0, 99) < 20);
            p = ($urandom_range(0, 99) < 15);
            v = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            applyStimulus(r, l, v, s, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer8.md
# countdown_timer8

Loadable, pausable down-counter with a clock prescaler and one-cycle completion pulse. It is the countdown counterpart to the team's free-running 8-bit up-counter. It serves as the timing element for lab sequencers and delay generation: software or an FSM loads a count, starts it, and waits for `done`.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits.
- `PRESCALE`, default 1: clocks per decrement; legal range 1..2^16−1.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `load`, input, 1: load `load_val` into counter and reload register.
- `load_val`, input, `WIDTH`: value to load.
- `start`, input, 1: begin countdown from IDLE.
- `pause`, input, 1: level; freezes counting while high in RUN/HOLD.
- `cnt`, output, `WIDTH`: current count, registered.
- `busy`, output, 1: high in RUN or HOLD.
- `done`, output, 1: one-cycle pulse when count reaches 0.
- `zero`, output, 1: `cnt == 0`.

## Operation
- Reset (`rst`=1 at an edge): `cnt`=0, reload register=0, prescaler=0, state IDLE. After reset, `busy`=0, `done`=0, `zero`=1. Reset overrides all other inputs.
- Priority below reset is `load` > `pause` > tick > `start`.
- `load` is accepted in any state. It sets `cnt` and the reload register to `load_val`, clears the prescaler, and moves the state to IDLE. It does not pulse `done`. Loading mid-RUN aborts the count.
- States are IDLE, RUN, HOLD and DONE:
  - IDLE: `start` with `cnt`≠0 goes to RUN and clears the prescaler. `start` with `cnt`=0 goes to DONE and pulses `done` at that same edge. Otherwise the state holds.
  - RUN: the prescaler counts 0..PRESCALE−1; tick means the prescaler is at PRESCALE−1 and not paused. On a tick, `cnt` decrements and the prescaler returns to 0. A tick with `cnt`=1 sets `cnt` to 0 and `done` to 1, and the state goes to DONE. `pause`=1 goes to HOLD with the prescaler frozen; if `pause` and a tick coincide, `pause` wins and no decrement occurs. `start` is ignored.
  - HOLD: `cnt` and the prescaler are frozen. `pause`=0 returns to RUN and the prescaler resumes from its held value. `start` is ignored.
  - DONE: lasts exactly one cycle. `done` is cleared at the next edge, and the next state is set by the configuration below.
- Counting never wraps: `cnt` never goes below 0 and never passes from 0 to 2^WIDTH−1.
- `busy` and `done` are registered. `zero` is combinational from the `cnt` register.

## Timing
- After `start` is sampled at edge E, with no pause, decrements occur at edges E+k·PRESCALE for k=1..N.
- With N = the loaded count, `cnt` reaches 0 and `done`=1 at edge E+N·PRESCALE. `done` is high for exactly that one cycle.
- `busy` rises at edge E and falls at the edge where `done` rises.
- Each cycle spent in HOLD extends completion by exactly one cycle.
- `load` takes effect at the sampling edge, so `cnt` shows `load_val` in the next cycle.

## Configuration
- Macro `COUNTDOWN_AUTO_RELOAD_EN`.
- Defined: DONE loads `cnt` from the reload register and goes to RUN with the prescaler cleared, giving a periodic `done` every N·PRESCALE+1 cycles. If the reload register holds 0, DONE goes to IDLE instead. `busy` stays low only during the DONE cycle.
- Undefined: DONE goes to IDLE with `cnt`=0. No reload register is synthesized; `load` writes `cnt` only.

## Structure
- Package `timer_pkg` holds:
  - the state enum (IDLE, RUN, HOLD, DONE);
  - the localparam for prescaler width, $clog2(PRESCALE+1).
- Sub-module `tick_prescaler` contains the prescaler counter. Its ports are `clk`, `rst`, `clr`, `en`, and output `tick`. It is instantiated once.
- The top level contains the FSM, `cnt`, the reload register, and the outputs.

## Test plan
- Reset with `load`=1 and `start`=1 both asserted → next cycle `cnt`=0, `busy`=0, `done`=0, `zero`=1.
- PRESCALE=1: load 5, then start at edge E → `cnt` goes 4,3,2,1,0 at E+1..E+5; `done`=1 only in the cycle after E+5; `busy` falls at E+5.
- PRESCALE=3: load 2, start, hold `pause` high for 4 cycles starting mid-prescale → `done` arrives at E+6+4; `cnt` is stable throughout the pause.
- Load 0, then start → `done` pulses at the start edge; `busy` never rises.
- Load 200 and start; at `cnt`=120, load 7 → `cnt`=7, state IDLE, no `done` pulse; then start → `done` after 7·PRESCALE cycles.
- With `COUNTDOWN_AUTO_RELOAD_EN` defined and PRESCALE=1: load 3, start → `done` pulses repeat every 4 cycles until `load` or `rst`.
